// File: rtl/inst_queue_if.sv
// Fetch/dispatch bundle for inst_queue; perf counter signals exist only with INST_QUEUE_PERF_EN.
interface inst_queue_if #(
  parameter int DEPTH = 8,
  parameter int N     = 4,
  parameter int F     = 4,
  parameter int W     = 32
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(F + 1);
  localparam int DW = $clog2(N + 1);

  logic                flush;
  logic [F-1:0][W-1:0] in_insts;
  logic [IW-1:0]       in_count;
  logic [DW-1:0]       num_dispatch;
  logic [IW-1:0]       in_accepted;
  logic [N-1:0][W-1:0] dispatched_insts;
  logic [N-1:0]        out_valid;
  logic [CW-1:0]       count;
  logic [CW-1:0]       open_entries;
  logic                full;
  logic                empty;

`ifdef INST_QUEUE_PERF_EN
  logic [31:0] perf_full_cycles;
  logic [31:0] perf_accepted;
  logic [15:0] perf_flushes;

  modport master (
    output flush, in_insts, in_count, num_dispatch,
    input  in_accepted, dispatched_insts, out_valid, count, open_entries, full, empty,
    input  perf_full_cycles, perf_accepted, perf_flushes
  );
  modport slave (
    input  flush, in_insts, in_count, num_dispatch,
    output in_accepted, dispatched_insts, out_valid, count, open_entries, full, empty,
    output perf_full_cycles, perf_accepted, perf_flushes
  );
`else
  modport master (
    output flush, in_insts, in_count, num_dispatch,
    input  in_accepted, dispatched_insts, out_valid, count, open_entries, full, empty
  );
  modport slave (
    input  flush, in_insts, in_count, num_dispatch,
    output in_accepted, dispatched_insts, out_valid, count, open_entries, full, empty
  );
`endif
endinterface

// File: rtl/inst_queue.sv
// Multi-lane instruction queue between fetch and dispatch with all-or-nothing accept and flush.
// Optional saturating perf counters are enabled by defining INST_QUEUE_PERF_EN.
`ifndef INST_BUFF_DEPTH
`define INST_BUFF_DEPTH 8
`endif
`ifndef N
`define N 4
`endif

module inst_queue #(
  parameter int DEPTH = `INST_BUFF_DEPTH,
  parameter int N     = `N,
  parameter int F     = `N,
  parameter int W     = 32
) (
  input logic         clock,
  input logic         reset,
  inst_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  entries [DEPTH];
  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] eff_dispatch;
  logic [CW-1:0] free_slots;
  logic [CW-1:0] accept_num;
  logic          accept_ok;
  logic [PW-1:0] wr_addr [F];
  logic [PW-1:0] rd_addr [N];

  // Offsets never exceed DEPTH, so one conditional subtract wraps any depth.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr, input logic [CW-1:0] k);
    logic [SW-1:0] sum;
    sum = SW'(ptr) + SW'(k);
    if (sum >= SW'(DEPTH))
      sum = sum - SW'(DEPTH);
    return sum[PW-1:0];
  endfunction

  always_comb begin
    eff_dispatch = (CW'(bus.num_dispatch) < count_reg) ? CW'(bus.num_dispatch) : count_reg;
    free_slots   = CW'(DEPTH) - count_reg + eff_dispatch;
    accept_ok    = !bus.flush && (CW'(bus.in_count) <= free_slots);
    accept_num   = accept_ok ? CW'(bus.in_count) : '0;
    head_next    = ptr_add(head_reg, eff_dispatch);
    tail_next    = ptr_add(tail_reg, accept_num);
    count_next   = count_reg - eff_dispatch + accept_num;
  end

  generate
    for (genvar gi = 0; gi < F; gi++) begin : g_wr
      assign wr_addr[gi] = ptr_add(tail_reg, CW'(gi));
    end
    for (genvar gi = 0; gi < N; gi++) begin : g_rd
      assign rd_addr[gi]              = ptr_add(head_reg, CW'(gi));
      assign bus.dispatched_insts[gi] = entries[rd_addr[gi]];
      assign bus.out_valid[gi]        = CW'(gi) < count_reg;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++)
        entries[i] <= '0;
    end else if (bus.flush) begin
      // Payloads are deliberately left in place; only the pointers are squashed.
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      for (int j = 0; j < F; j++)
        if (accept_ok && (j < int'(bus.in_count)))
          entries[wr_addr[j]] <= bus.in_insts[j];
    end
  end

  assign bus.in_accepted  = accept_ok ? bus.in_count : '0;
  assign bus.count        = count_reg;
  assign bus.open_entries = free_slots;
  assign bus.full         = (count_reg == CW'(DEPTH));
  assign bus.empty        = (count_reg == '0);

`ifdef INST_QUEUE_PERF_EN
  logic [31:0] perf_full_cycles_reg;
  logic [31:0] perf_accepted_reg;
  logic [15:0] perf_flushes_reg;
  logic [32:0] perf_accepted_next;

  assign perf_accepted_next = {1'b0, perf_accepted_reg} + 33'(bus.in_accepted);

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_full_cycles_reg <= '0;
      perf_accepted_reg    <= '0;
      perf_flushes_reg     <= '0;
    end else begin
      if (bus.full && (bus.in_count != '0) && !accept_ok && (perf_full_cycles_reg != '1))
        perf_full_cycles_reg <= perf_full_cycles_reg + 32'd1;
      perf_accepted_reg <= perf_accepted_next[32] ? '1 : perf_accepted_next[31:0];
      if (bus.flush && (perf_flushes_reg != '1))
        perf_flushes_reg <= perf_flushes_reg + 16'd1;
    end
  end

  assign bus.perf_full_cycles = perf_full_cycles_reg;
  assign bus.perf_accepted    = perf_accepted_reg;
  assign bus.perf_flushes     = perf_flushes_reg;
`endif
endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Parametrised successor to the fetch-side instruction buffer; sits between fetch and dispatch.
- Accepts up to F instructions per cycle and presents up to N oldest instructions to dispatch.
- Adds per-lane output valids, all-or-nothing accept handshake, dispatch clamping to occupancy, and a synchronous flush for mispredict recovery.
- Depth need not be a power of two.

Parameters:
- DEPTH, `INST_BUFF_DEPTH: number of entries; must be ≥ max(N, F).
- N, `N: dispatch width (output lanes).
- F, `N: fetch width (input lanes).

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- flush  in  1  squash all entries (mispredict/exception).
- in_insts  in  F x INST_PACKET  fetch lanes; lanes 0..in_count-1 meaningful.
- in_count  in  $clog2(F+1)  number of valid input lanes, contiguous from lane 0.
- num_dispatch  in  $clog2(N+1)  instructions consumed by dispatch this cycle.
- in_accepted  out  $clog2(F+1)  lanes written this cycle (0 or in_count).
- dispatched_insts  out  N x INST_PACKET  lane i = entry at (head+i) wrapped.
- out_valid  out  N  bit i = (i < count).
- count  out  $clog2(DEPTH+1)  current occupancy (registered).
- open_entries  out  $clog2(DEPTH+1)  DEPTH - count + eff_dispatch (combinational).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- State: head, tail (0..DEPTH-1), count (0..DEPTH), entries[DEPTH].
- Pointers wrap explicitly: ptr + k ≥ DEPTH ⇒ subtract DEPTH. No reliance on power-of-two modulo.
- Dispatch: eff_dispatch = min(num_dispatch, count). Requests beyond occupancy are silently clamped and never underflow count.
- Accept: free = DEPTH - count + eff_dispatch.
  - If in_count ≤ free and !flush: write in_insts[j] to entries[tail+j] for j < in_count; in_accepted = in_count.
  - Otherwise nothing is written; in_accepted = 0. There is no partial accept; fetch must resend the whole group.
- Same-cycle dispatch and accept are both legal, including at full. Space freed by dispatch is usable the same cycle.
- Next state (no flush):
  - head += eff_dispatch
  - tail += in_accepted
  - count = count - eff_dispatch + in_accepted
- Flush takes priority over everything: next head = tail = count = 0. Input is ignored (in_accepted = 0) and dispatch is ignored.
- During the flush cycle, out_valid and dispatched_insts still reflect pre-flush contents; dispatch must qualify with flush.
- Flush does not clear entry payloads.
- Output latency: entries written in cycle t are visible on dispatched_insts / out_valid in cycle t+1. There is no same-cycle bypass.
- Reset (synchronous): head = tail = count = 0 and entries = '0.
  - Outputs after reset: out_valid = 0, count = 0, empty = 1, full = 0, dispatched_insts = '0.
  - open_entries = DEPTH and in_accepted = in_count (if in_count ≤ DEPTH).
- Reset mid-operation discards all contents; reset has priority over flush.
- Combinational paths: num_dispatch → open_entries / in_accepted. No path from in_insts to any output.

Optional Feature:
- Macro: INST_QUEUE_PERF_EN.
- When defined, adds outputs:
  - perf_full_cycles (32b): increments each cycle full==1 && in_count != 0 && in_accepted == 0.
  - perf_accepted (32b): accumulates in_accepted.
  - perf_flushes (16b): increments on flush.
- All counters saturate, are cleared only by reset, and are unaffected by flush.
- When not defined, these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- DEPTH=8, N=F=4. After reset, push in_count=3 (A,B,C) with num_dispatch=0 → next cycle count=3, out_valid=0111, lanes 0..2 = A,B,C, open_entries=5.
- With count=3, request num_dispatch=4 → eff_dispatch=3, next count=0, empty=1, no underflow.
- Fill to count=6; in_count=4, num_dispatch=0 → in_accepted=0, count stays 6.
  - Same stimulus with num_dispatch=2 → in_accepted=4, next count=8, full=1.
- Wrap check: cycle head through index 7→0 with sustained 3-in / 3-out for 10 cycles → dispatched order equals push order exactly, no duplicates or drops.
- Flush at count=5 with in_count=2, num_dispatch=1 → in_accepted=0 that cycle; next cycle count=0, out_valid=0000, head=tail=0.
- Assert reset while count=7 and a flush is pending → next cycle count=0, entries all zero, open_entries=8.
